// File: rtl/motion_bbox.sv
// Motion bounding-box accumulator.
// Gathers the min/max coordinates and the number of foreground pixels over one frame of
// the binary motion mask, then publishes the result through a valid/ready handshake.
// Optional feature macro: BBOX_OVERLAY_EN adds the ovl_pix overlay output.
module motion_bbox #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned MIN_COUNT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  input  logic        in_pix,
  input  logic        box_ready,
  output logic        box_valid,
  output logic        box_found,
  output logic [10:0] box_x0,
  output logic [10:0] box_x1,
  output logic [10:0] box_y0,
  output logic [10:0] box_y1,
  output logic [19:0] box_count,
  output logic        overrun
`ifdef BBOX_OVERLAY_EN
  ,
  output logic        ovl_pix
`endif
);

  typedef enum logic [1:0] {StIdle, StAccum, StPublish} state_e;

  state_e      state_q, state_d;
  logic [10:0] acc_x0_q, acc_x0_d, acc_x1_q, acc_x1_d;
  logic [10:0] acc_y0_q, acc_y0_d, acc_y1_q, acc_y1_d;
  logic [19:0] acc_count_q, acc_count_d;

  logic        valid_q, valid_d;
  logic        found_q, found_d;
  logic [10:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [19:0] count_q, count_d;
  logic        overrun_q, overrun_d;

  logic active, frame_start, frame_last, accumulate, publish, found_now;

  assign active      = (hpos < 11'(H_ACTIVE)) && (vpos < 11'(V_ACTIVE));
  assign frame_start = (hpos == 11'd0) && (vpos == 11'd0);
  assign frame_last  = (hpos == 11'(H_ACTIVE - 1)) && (vpos == 11'(V_ACTIVE - 1));
  assign publish     = (state_q == StPublish);
  assign found_now   = (acc_count_q >= 20'(MIN_COUNT));

  // Frame FSM and bounding-box accumulators.
  always_comb begin
    state_d     = state_q;
    acc_x0_d    = acc_x0_q;
    acc_x1_d    = acc_x1_q;
    acc_y0_d    = acc_y0_q;
    acc_y1_d    = acc_y1_q;
    acc_count_d = acc_count_q;
    accumulate  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Only a frame seen from its very first pixel is ever published.
        if (frame_start) begin
          accumulate = 1'b1;
          state_d    = frame_last ? StPublish : StAccum;
        end
      end
      StAccum: begin
        accumulate = 1'b1;
        if (frame_last) state_d = StPublish;
      end
      StPublish: begin
        state_d     = StIdle;
        acc_x0_d    = '1;
        acc_x1_d    = '0;
        acc_y0_d    = '1;
        acc_y1_d    = '0;
        acc_count_d = '0;
      end
      default: state_d = StIdle;
    endcase
    if (accumulate && active && in_pix) begin
      if (hpos < acc_x0_q) acc_x0_d = hpos;
      if (hpos > acc_x1_q) acc_x1_d = hpos;
      if (vpos < acc_y0_q) acc_y0_d = vpos;
      if (vpos > acc_y1_q) acc_y1_d = vpos;
      if (acc_count_q != '1) acc_count_d = acc_count_q + 20'd1;
    end
  end

  // Result registers and valid/ready handshake.
  always_comb begin
    valid_d   = valid_q;
    found_d   = found_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (publish) begin
      valid_d = 1'b1;
      found_d = found_now;
      x0_d    = found_now ? acc_x0_q : 11'd0;
      x1_d    = found_now ? acc_x1_q : 11'd0;
      y0_d    = found_now ? acc_y0_q : 11'd0;
      y1_d    = found_now ? acc_y1_q : 11'd0;
      count_d = acc_count_q;
      // Overwriting a result nobody has taken yet is sticky until reset.
      if (valid_q && !box_ready) overrun_d = 1'b1;
    end else if (valid_q && box_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_x0_q    <= '1;
      acc_x1_q    <= '0;
      acc_y0_q    <= '1;
      acc_y1_q    <= '0;
      acc_count_q <= '0;
      valid_q     <= 1'b0;
      found_q     <= 1'b0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_x0_q    <= acc_x0_d;
      acc_x1_q    <= acc_x1_d;
      acc_y0_q    <= acc_y0_d;
      acc_y1_q    <= acc_y1_d;
      acc_count_q <= acc_count_d;
      valid_q     <= valid_d;
      found_q     <= found_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign box_valid = valid_q;
  assign box_found = found_q;
  assign box_x0    = x0_q;
  assign box_x1    = x1_q;
  assign box_y0    = y0_q;
  assign box_y1    = y1_q;
  assign box_count = count_q;
  assign overrun   = overrun_q;

`ifdef BBOX_OVERLAY_EN
  logic ovl_q, ovl_d, on_vert, on_horz;

  // Draw the 1-pixel border of the last published box (only if it was found) over the mask.
  always_comb begin
    on_vert = ((hpos == x0_q) || (hpos == x1_q)) && (vpos >= y0_q) && (vpos <= y1_q);
    on_horz = ((vpos == y0_q) || (vpos == y1_q)) && (hpos >= x0_q) && (hpos <= x1_q);
    ovl_d   = active && (in_pix || (found_q && (on_vert || on_horz)));
  end

  // Overlay output register.
  always_ff @(posedge clk) begin
    if (!rst_n) ovl_q <= 1'b0;
    else        ovl_q <= ovl_d;
  end

  assign ovl_pix = ovl_q;
`endif

endmodule

// File: tb/tb_motion_bbox.sv
// Scoreboard bench for motion_bbox: frames are driven as sparse coordinate lists, the
// expected box is computed from each list and queued, and a monitor checks every transfer.
module tb_motion_bbox;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hpos, vpos;
  logic        in_pix, box_ready;
  logic        box_valid, box_found, overrun;
  logic [10:0] box_x0, box_x1, box_y0, box_y1;
  logic [19:0] box_count;
`ifdef BBOX_OVERLAY_EN
  logic        ovl_pix;
`endif

  motion_bbox dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hpos      (hpos),
    .vpos      (vpos),
    .in_pix    (in_pix),
    .box_ready (box_ready),
    .box_valid (box_valid),
    .box_found (box_found),
    .box_x0    (box_x0),
    .box_x1    (box_x1),
    .box_y0    (box_y0),
    .box_y1    (box_y1),
    .box_count (box_count),
    .overrun   (overrun)
`ifdef BBOX_OVERLAY_EN
    ,
    .ovl_pix   (ovl_pix)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit found;
    int x0, x1, y0, y1, count;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_overrun;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fh[$], fv[$];
  bit   fp[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bounding box of the active foreground pixels listed in the frame.
  function automatic exp_t model();
    exp_t e;
    int cnt = 0, mnx = 4096, mxx = -1, mny = 4096, mxy = -1;
    foreach (fh[i]) begin
      if (fh[i] < 640 && fv[i] < 480 && fp[i]) begin
        cnt++;
        if (fh[i] < mnx) mnx = fh[i];
        if (fh[i] > mxx) mxx = fh[i];
        if (fv[i] < mny) mny = fv[i];
        if (fv[i] > mxy) mxy = fv[i];
      end
    end
    e.count = cnt;
    e.found = (cnt >= 16);
    e.x0 = e.found ? mnx : 0;
    e.x1 = e.found ? mxx : 0;
    e.y0 = e.found ? mny : 0;
    e.y1 = e.found ? mxy : 0;
    return e;
  endfunction

  task automatic pix(input int h, input int v, input bit p);
    hpos   = 11'(h);
    vpos   = 11'(v);
    in_pix = p;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) pix(700, 500, 1'($urandom));
  endtask

  task automatic add(input int h, input int v, input bit p);
    fh.push_back(h);
    fv.push_back(v);
    fp.push_back(p);
  endtask

  task automatic new_frame(input bit p0);
    fh.delete();
    fv.delete();
    fp.delete();
    add(0, 0, p0);
  endtask

  // Drive the listed frame (closing it with the last active pixel) and queue its result.
  task automatic run_frame(input bit plast);
    exp_t e;
    add(639, 479, plast);
    foreach (fh[i]) pix(fh[i], fv[i], fp[i]);
    e = model();
    // A result still queued here was never accepted, so this one overwrites it.
    if (exp_q.size() != 0) begin
      exp_q[0]    = e;
      exp_overrun = 1'b1;
    end else begin
      exp_q.push_back(e);
    end
    gap(6);
  endtask

  task automatic random_frame();
    int h, v;
    int n = $urandom_range(5, 60);
    new_frame(1'($urandom));
    repeat (n) begin
      do begin
        h = $urandom_range(0, 760);
        v = $urandom_range(0, 560);
      end while (h == 639 && v == 479);
      add(h, v, ($urandom % 4) != 0);
    end
    run_frame(1'($urandom));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, box_valid, 0);
    check({tag, "_found"}, box_found, 0);
    check({tag, "_coords"}, box_x0 | box_x1 | box_y0 | box_y1, 0);
    check({tag, "_count"}, box_count, 0);
    check({tag, "_overrun"}, overrun, 0);
`ifdef BBOX_OVERLAY_EN
    check({tag, "_ovl"}, ovl_pix, 0);
`endif
  endtask

  // Monitor: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && box_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else if (box_ready) begin
        check("found", box_found, exp_q[0].found);
        check("x0", box_x0, exp_q[0].x0);
        check("x1", box_x1, exp_q[0].x1);
        check("y0", box_y0, exp_q[0].y0);
        check("y1", box_y1, exp_q[0].y1);
        check("count", box_count, exp_q[0].count);
        check("overrun", overrun, exp_overrun);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int snap;
    rst_n       = 1'b0;
    box_ready   = 1'b1;
    exp_overrun = 1'b0;
    hpos        = 11'd700;
    vpos        = 11'd500;
    in_pix      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    gap(3);

    // Test 1: two rectangles on one band, plus foreground in blanking that must be ignored.
    new_frame(1'b0);
    add(700, 10, 1'b1);
    add(300, 600, 1'b1);
    for (int v = 6; v <= 99; v++) begin
      for (int h = 21; h <= 249; h++) begin
        if (h <= 200 || h >= 206) add(h, v, 1'b1);
      end
    end
    add(400, 300, 1'b0);
    run_frame(1'b0);
    check("t1_model_count", int'(box_count), 21056);

`ifdef BBOX_OVERLAY_EN
    pix(21, 50, 1'b0);
    check("ovl_border", ovl_pix, 1);
    pix(22, 50, 1'b0);
    check("ovl_inside", ovl_pix, 0);
    pix(22, 50, 1'b1);
    check("ovl_mask", ovl_pix, 1);
    pix(249, 800, 1'b1);
    check("ovl_blank", ovl_pix, 0);
`endif

    // Test 2: empty frame.
    new_frame(1'b0);
    run_frame(1'b0);

    // Test 3: ten isolated pixels stay below the noise threshold.
    new_frame(1'b0);
    for (int i = 0; i < 10; i++) add(100 + i * 30, 50 + i * 20, 1'b1);
    run_frame(1'b0);

    // Test 4: two unaccepted frames -> overrun, second frame's data kept.
    box_ready = 1'b0;
    random_frame();
    check("t4_valid_held", box_valid, 1);
    snap = int'(box_count);
    gap(3);
    check("t4_stable", int'(box_count), snap);
    random_frame();
    check("t4_overrun", overrun, 1);
    box_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_valid_drop", box_valid, 0);

    // Test 5: one-cycle reset in the middle of a frame.
    new_frame(1'b1);
    foreach (fh[i]) pix(fh[i], fv[i], fp[i]);
    for (int v = 10; v < 200; v += 10) pix(60, v, 1'b1);
    rst_n = 1'b0;
    pix(30, 200, 1'b1);
    rst_n = 1'b1;
    exp_q.delete();
    exp_overrun = 1'b0;
    check_zero("midreset");
    for (int v = 201; v < 210; v++) pix(50, v, 1'b1);
    pix(639, 479, 1'b1);
    gap(6);
    check("partial_not_published", box_valid, 0);
    random_frame();

    // Randomised frames with random backpressure held per frame.
    for (int f = 0; f < 10; f++) begin
      box_ready = ($urandom % 3) != 0;
      random_frame();
    end

    box_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) gap(1);
    if (exp_q.size() != 0) check("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
